// File: rtl/man_txdy.sv
// Manchester frame transmitter: DATA_NUM payload bits LSB first, a CCITT CRC-16 MSB first,
// then an idle-high gap. Every output is registered; txd idles high.
module man_txdy #(
  parameter int unsigned CLK_DIV  = 24,
  parameter int unsigned DATA_NUM = 50,
  parameter int unsigned CRC_NUM  = 48,
  parameter int unsigned GAP_HALF = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_NUM-1:0] data_in,
  output logic                txd,
  output logic                busy,
  output logic                done,
  output logic [15:0]         crc_out
);

  localparam int unsigned HalfW  = $clog2(CLK_DIV + 2);
  localparam int unsigned BitW   = ($clog2(DATA_NUM) > 4) ? $clog2(DATA_NUM) : 4;
  localparam int unsigned GapLen = GAP_HALF * (CLK_DIV + 1);
  localparam int unsigned GapW   = $clog2(GapLen + 1);
  localparam logic [15:0] Poly   = 16'h1021;

  typedef enum logic [1:0] {StIdle, StData, StCrc, StGap} state_e;

  state_e              state_q, state_d;
  logic [HalfW-1:0]    half_cnt_q, half_cnt_d;
  logic                phase_q, phase_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DATA_NUM-1:0] shift_q, shift_d;
  logic [15:0]         crc_q, crc_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic        half_end, first_half_end, bit_end;
  logic        crc_cov;
  logic [15:0] crc_step, crc_new;
  logic [3:0]  crc_idx_cur, crc_idx_nxt;

  always_comb begin
    half_end       = (half_cnt_q == HalfW'(CLK_DIV));
    first_half_end = half_end & ~phase_q;
    bit_end        = half_end & phase_q;
    crc_cov        = (32'(bit_cnt_q) < CRC_NUM);
    crc_step       = {crc_q[14:0], 1'b0} ^ ((shift_q[0] ^ crc_q[15]) ? Poly : 16'h0000);
    crc_new        = crc_cov ? crc_step : crc_q;
    // CRC goes out MSB first, so bit index n selects crc_q[15-n]
    crc_idx_cur    = ~bit_cnt_q[3:0];
    crc_idx_nxt    = ~(bit_cnt_q[3:0] + 4'd1);
  end

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = StData;
          shift_d    = data_in;
          crc_d      = 16'h0000;
          half_cnt_d = '0;
          phase_d    = 1'b0;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          txd_d      = ~data_in[0];
        end
      end

      StData: begin
        half_cnt_d = half_end ? '0 : half_cnt_q + 1'b1;
        if (first_half_end) begin
          phase_d = 1'b1;
          txd_d   = shift_q[0];
        end else if (bit_end) begin
          phase_d = 1'b0;
          shift_d = shift_q >> 1;
          crc_d   = crc_new;
          if (bit_cnt_q == BitW'(DATA_NUM - 1)) begin
            state_d   = StCrc;
            bit_cnt_d = '0;
            txd_d     = ~crc_new[15];
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            txd_d     = ~shift_q[1];
          end
        end
      end

      StCrc: begin
        half_cnt_d = half_end ? '0 : half_cnt_q + 1'b1;
        if (first_half_end) begin
          phase_d = 1'b1;
          txd_d   = crc_q[crc_idx_cur];
        end else if (bit_end) begin
          phase_d = 1'b0;
          if (bit_cnt_q[3:0] == 4'd15) begin
            state_d   = StGap;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            txd_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            txd_d     = ~crc_q[crc_idx_nxt];
          end
        end
      end

      StGap: begin
        txd_d = 1'b1;
        if (gap_cnt_q == GapW'(GapLen - 1)) begin
          state_d   = StIdle;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          // registered pulse lands on the final gap cycle
          done_d    = (gap_cnt_q == GapW'(GapLen - 2));
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      shift_q    <= '0;
      crc_q      <= 16'h0000;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_out = crc_q;

endmodule
